uart_rx_fifo: RTL

Parametrised UART receiver with 16x oversampling, majority-vote bit sampling, configurable word width, parity and stop bits. Received words and their per-word error flags go into a show-ahead receive FIFO. It replaces the fixed 8-bit receive path of `UART` and sits between the serial pin and the host-side consumer. A full FIFO produces a sticky overrun flag and never corrupts stored data.

---
 rtl/uart_rx_fifo.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver (16x oversampling, 2-of-3 vote) feeding a show-ahead word+flags FIFO; `UART_RX_BREAK_DET_EN adds break detection.
// A word is visible the clock after PUSH; a push into a full FIFO is dropped and sets sticky overrun.
module uart_rx_fifo #(
  parameter int CLK_DIV    = 4,
  parameter int DATA_W     = 8,
  parameter int PARITY     = 1,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          rd_en,
  output logic [DATA_W-1:0]             DATA_out,
  output logic                          parity_error,
  output logic                          stop_error,
  output logic                          op_valid,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          break_det
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;
  localparam int BW    = $clog2(DATA_W);
  localparam int WW    = DATA_W + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_PUSH,
    S_BRK
  } state_t;

  state_t state, state_nxt;

  logic rx_s1, rx_s2, rx_d;
  logic start_edge;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign start_edge = rx_d & ~rx_s2;

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             div_clr;
  logic [3:0]       tick_cnt;
  logic             frame_init;

  assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (div_clr || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (frame_init) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= tick_cnt + 4'd1;
    end
  end

  // Ticks 7 and 8 are held; tick 9 votes with the live synchronised value.
  logic s7, s8, maj, eval;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s7 <= 1'b1;
      s8 <= 1'b1;
    end else if (tick) begin
      if (tick_cnt == 4'd7) s7 <= rx_s2;
      if (tick_cnt == 4'd8) s8 <= rx_s2;
    end
  end

  assign maj  = (s7 & s8) | (s7 & rx_s2) | (s8 & rx_s2);
  assign eval = tick && (tick_cnt == 4'd9);

  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     bit_cnt;
  logic              stop_cnt;
  logic              par_err;
  logic              stop_err;
  logic              exp_par;
  logic              shift_en, par_chk, stop_chk, push_en;

  assign exp_par = (PARITY == 2) ? ~(^shreg) : ^shreg;

`ifdef UART_RX_BREAK_DET_EN
  logic all_zero;
  logic brk_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      all_zero <= 1'b0;
    end else if (frame_init) begin
      all_zero <= 1'b1;
    end else if (shift_en || par_chk || stop_chk) begin
      all_zero <= all_zero & ~maj;
    end
  end

  assign break_det = brk_hit;
`else
  assign break_det = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_edge) state_nxt = S_START;
      S_START: if (eval) state_nxt = maj ? S_IDLE : S_DATA;
      S_DATA:  if (eval && (bit_cnt == BW'(DATA_W - 1)))
                 state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:   if (eval) state_nxt = S_STOP;
      S_STOP:  if (eval && (stop_cnt == 1'(STOP_BITS - 1))) state_nxt = S_PUSH;
`ifdef UART_RX_BREAK_DET_EN
      S_PUSH:  state_nxt = all_zero ? S_BRK : S_IDLE;
      S_BRK:   if (tick && rx_s2) state_nxt = S_IDLE;
`else
      S_PUSH:  state_nxt = S_IDLE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    div_clr    = 1'b0;
    frame_init = 1'b0;
    shift_en   = 1'b0;
    par_chk    = 1'b0;
    stop_chk   = 1'b0;
    push_en    = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    brk_hit    = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        div_clr    = start_edge;
        frame_init = start_edge;
      end
      S_DATA: shift_en = eval;
      S_PAR:  par_chk  = eval;
      S_STOP: stop_chk = eval;
`ifdef UART_RX_BREAK_DET_EN
      S_PUSH: begin
        push_en = ~all_zero;
        brk_hit = all_zero;
        div_clr = 1'b1;
      end
      // Any low sample restarts the one-tick high qualification.
      S_BRK:  div_clr = ~rx_s2;
`else
      S_PUSH: push_en = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_err  <= 1'b0;
      stop_err <= 1'b0;
    end else if (frame_init) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_err  <= 1'b0;
      stop_err <= 1'b0;
    end else begin
      if (shift_en) begin
        shreg   <= {maj, shreg[DATA_W-1:1]};
        bit_cnt <= bit_cnt + BW'(1);
      end
      if (par_chk) par_err <= maj ^ exp_par;
      if (stop_chk) begin
        stop_cnt <= stop_cnt + 1'b1;
        if (!maj) stop_err <= 1'b1;
      end
    end
  end

  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr, rptr_nxt;
  logic [CW-1:0] count, cnt_nxt;
  logic [WW-1:0] din, head_q, head_nxt;
  logic          full, empty, pop, push_ok, drop;

  assign din      = {stop_err, (PARITY != 0) ? par_err : 1'b0, shreg};
  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign pop      = rd_en && op_valid;
  assign push_ok  = push_en && (!full || pop);
  assign drop     = push_en && full && !pop;
  assign cnt_nxt  = count + CW'(push_ok) - CW'(pop);
  assign rptr_nxt = pop ? rptr + PW'(1) : rptr;

  // The head register is loaded from next-state so every output is a flop.
  always_comb begin
    head_nxt = '0;
    if (cnt_nxt != '0) begin
      if (push_ok && (empty || ((count == CW'(1)) && pop))) begin
        head_nxt = din;
      end else begin
        head_nxt = mem[rptr_nxt];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      head_q   <= '0;
      op_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + PW'(1);
      rptr     <= rptr_nxt;
      count    <= cnt_nxt;
      head_q   <= head_nxt;
      op_valid <= (cnt_nxt != '0);
      if (drop) begin
        overrun <= 1'b1;
      end else if (pop) begin
        overrun <= 1'b0;
      end
    end
  end

  assign DATA_out     = head_q[DATA_W-1:0];
  assign parity_error = head_q[DATA_W];
  assign stop_error   = head_q[DATA_W+1];
  assign fifo_count   = count;

endmodule
